bridge_mem_arbiter: RTL and testbench
=====================================

// Module: bridge_mem_arbiter
// PURPOSE
//  N-channel round-robin arbiter that funnels independent requesters onto the single
//  external bridge_memory master port (address/byte_enable/read/write/acknowledge).
//  It sits between the HPS/host-side logic and the Qsys bridge.
//  It generalises that port in data width, address width and requester count.
//  It serialises transfers and returns read data and ack per channel.
// PARAMETERS
//  N_CH        4    number of requester channels (2..8)
//  ADDR_W      27   byte address width
//  DATA_W      16   data width; multiple of 8
//  BE_W        DATA_W/8  byte-enable width (derived, localparam)
//  TIMEOUT_CYC 255  ack watchdog limit in cycles (used only with BRIDGE_TIMEOUT_EN)
// PORTS
//  clk_clk                   in  1            system clock
//  reset_reset               in  1            async reset, active-high
//  req_read                  in  N_CH         per-channel read request (level)
//  req_write                 in  N_CH         per-channel write request (level)
//  req_addr                  in  N_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
//  req_be                    in  N_CH*BE_W    per-channel byte enables
//  req_wdata                 in  N_CH*DATA_W  per-channel write data
//  req_ack                   out N_CH         one-cycle completion pulse, one-hot
//  req_rdata                 out DATA_W       read data, valid on the cycle of req_ack
//  bridge_memory_address     out ADDR_W       to bridge
//  bridge_memory_byte_enable out BE_W         to bridge
//  bridge_memory_read        out 1            to bridge
//  bridge_memory_write       out 1            to bridge
//  bridge_memory_write_data  out DATA_W       to bridge
//  bridge_memory_acknowledge in  1            from bridge
//  bridge_memory_read_data   in  DATA_W       from bridge
//  err_timeout               out 1            sticky watchdog flag
//  err_ch                    out clog2(N_CH)  channel that timed out
// BEHAVIOUR
//  - Reset: all outputs 0. FSM=IDLE. RR pointer=0. Watchdog count=0. Reset mid-transfer drops strobes immediately; no ack is issued.
//  - Requester protocol: assert read or write with stable addr/be/wdata until its req_ack pulse. Then drop the request or present the next one.
//  - read&write both high on one channel: treated as a write.
//  - FSM IDLE: if any request is pending, grant the lowest index >= RR pointer (wrapping mod N_CH).
//    Register addr/be/wdata and the strobe into the bridge outputs -> ISSUE (strobe visible 1 cycle after grant).
//  - FSM ISSUE: hold all bridge outputs constant until acknowledge=1.
//    On that cycle, capture read_data (reads only; writes give rdata=0) and drop the strobes -> DONE.
//  - FSM DONE: req_ack[grant]=1 and req_rdata valid for exactly 1 cycle. RR pointer <= grant+1 (wraps N_CH-1 -> 0). -> IDLE.
//  - Latency: request seen at cycle 0, strobe at cycle 1, ack at cycle k, req_ack at k+1. The next grant is evaluated at k+2.
//  - A request withdrawn before grant is ignored. A withdrawal after grant is illegal and does not abort the transfer.
//  - acknowledge seen in IDLE/DONE is ignored.
//  - Never more than one bridge strobe high. Never more than one outstanding transfer.
//  - req_rdata holds its last value between acks.
// CONFIGURATION
//  - BRIDGE_TIMEOUT_EN defined: a counter runs during ISSUE.
//    If TIMEOUT_CYC cycles pass without acknowledge: drop the strobes, go to DONE, ack the channel with req_rdata={DATA_W{1'b1}}.
//    Set err_timeout=1 (sticky until reset) and err_ch=grant.
//  - BRIDGE_TIMEOUT_EN undefined: ISSUE waits indefinitely. err_timeout=0 and err_ch=0 constant; the counter is not synthesised.
// TESTING
//  1. Single read: ch0 read addr=0x100, bridge acks 3 cycles after the strobe with 0xBEEF.
//     -> read high 3 cycles, req_ack=4'b0001 one cycle, req_rdata=0xBEEF.
//  2. Write: ch2 write addr=0x2A, be=2'b10, wdata=0x1234.
//     -> bridge outputs match exactly while write=1; req_ack=4'b0100.
//  3. Fairness: all 4 channels request reads continuously.
//     -> grant order 0,1,2,3,0,1. No channel is acked twice before the others are acked once.
//  4. Wrap/skip: RR pointer=3, only ch1 and ch3 pending -> ch3 first, then ch1.
//  5. Reset mid-ISSUE: assert reset_reset while write=1.
//     -> all bridge strobes 0 the same cycle, no req_ack. The FSM restarts at IDLE with pointer 0.
//  6. (BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8) ch1 read, never acked.
//     -> strobe drops after 8 cycles, req_ack=4'b0010, rdata=0xFFFF, err_timeout=1, err_ch=1.

Source files
------------

// File: rtl/bridge_mem_arbiter.sv
// rtl/bridge_mem_arbiter.sv - round-robin N-channel arbiter onto one bridge_memory master port (optional BRIDGE_TIMEOUT_EN ack watchdog)
module bridge_mem_arbiter #(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int BE_W       = DATA_W / 8,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [N_CH-1:0]          req_read,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*BE_W-1:0]     req_be,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          req_ack,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ADDR_W-1:0]        bridge_memory_address,
  output logic [BE_W-1:0]          bridge_memory_byte_enable,
  output logic                     bridge_memory_read,
  output logic                     bridge_memory_write,
  output logic [DATA_W-1:0]        bridge_memory_write_data,
  input  logic                     bridge_memory_acknowledge,
  input  logic [DATA_W-1:0]        bridge_memory_read_data,
  output logic                     err_timeout,
  output logic [CH_W-1:0]          err_ch
);

  if (N_CH < 2 || N_CH > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("bridge_mem_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] pick;
  logic            pick_vld;
  int              pick_idx;
  logic [N_CH-1:0] pending;
  logic            timeout_hit;

  assign pending = req_read | req_write;

  // Round-robin pick: lowest pending index at or after rr_ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    pick_idx = 0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      pick_idx = (int'(rr_ptr) + off) % N_CH;
      if (pending[pick_idx]) begin
        pick     = CH_W'(pick_idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and the per-channel completion pulse
  always_comb begin
    state_nxt = state;
    req_ack   = '0;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   if (bridge_memory_acknowledge || timeout_hit) state_nxt = DONE;
      DONE: begin
        req_ack[grant] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // Grant capture, bridge output registers, read data capture and pointer advance
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      grant                     <= '0;
      rr_ptr                    <= '0;
      req_rdata                 <= '0;
      bridge_memory_address     <= '0;
      bridge_memory_byte_enable <= '0;
      bridge_memory_read        <= 1'b0;
      bridge_memory_write       <= 1'b0;
      bridge_memory_write_data  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant                     <= pick;
          bridge_memory_address     <= req_addr[pick*ADDR_W +: ADDR_W];
          bridge_memory_byte_enable <= req_be[pick*BE_W +: BE_W];
          bridge_memory_write_data  <= req_wdata[pick*DATA_W +: DATA_W];
          // write wins when a channel raises both strobes
          bridge_memory_write       <= req_write[pick];
          bridge_memory_read        <= ~req_write[pick];
        end
        ISSUE: if (bridge_memory_acknowledge) begin
          req_rdata           <= bridge_memory_read ? bridge_memory_read_data : '0;
          bridge_memory_read  <= 1'b0;
          bridge_memory_write <= 1'b0;
        end else if (timeout_hit) begin
          req_rdata           <= '1;
          bridge_memory_read  <= 1'b0;
          bridge_memory_write <= 1'b0;
        end
        DONE: rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  // An ack on the final watchdog cycle still completes normally
  assign timeout_hit = (state == ISSUE) && !bridge_memory_acknowledge &&
                       (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counts ISSUE cycles, cleared outside ISSUE
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)          wd_cnt <= '0;
    else if (state == ISSUE)  wd_cnt <= wd_cnt + 1'b1;
    else                      wd_cnt <= '0;
  end

  // Sticky error flag with the offending channel
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      err_timeout <= 1'b0;
      err_ch      <= '0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
      err_ch      <= grant;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
  assign err_ch      = '0;
`endif

endmodule

// File: tb/tb_bridge_mem_arbiter.sv
// tb/tb_bridge_mem_arbiter.sv - scoreboard bench for bridge_mem_arbiter (BRIDGE_TIMEOUT_EN selects the watchdog scenario)
module tb_bridge_mem_arbiter;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;
  localparam int CH_W   = 2;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        req_read = '0;
  logic [N_CH-1:0]        req_write = '0;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*BE_W-1:0]   req_be;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [N_CH-1:0]        req_ack;
  logic [DATA_W-1:0]      req_rdata;
  logic [ADDR_W-1:0]      bridge_memory_address;
  logic [BE_W-1:0]        bridge_memory_byte_enable;
  logic                   bridge_memory_read;
  logic                   bridge_memory_write;
  logic [DATA_W-1:0]      bridge_memory_write_data;
  logic                   bridge_memory_acknowledge;
  logic [DATA_W-1:0]      bridge_memory_read_data = '0;
  logic                   err_timeout;
  logic [CH_W-1:0]        err_ch;

  logic [ADDR_W-1:0] ch_addr [N_CH];
  logic [BE_W-1:0]   ch_be   [N_CH];
  logic [DATA_W-1:0] ch_wd   [N_CH];

  typedef struct {
    int                ch;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;
  int   drv_rep [N_CH];
  int   resp_delay = 3;
  bit   resp_en = 1'b1;
  int   resp_cnt = 0;
  int   strobe_run = 0;
  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;

  assign bridge_memory_acknowledge = resp_ack | stray_ack;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign req_addr[g*ADDR_W +: ADDR_W] = ch_addr[g];
    assign req_be[g*BE_W +: BE_W]       = ch_be[g];
    assign req_wdata[g*DATA_W +: DATA_W] = ch_wd[g];
  end

  bridge_mem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .req_ack(req_ack), .req_rdata(req_rdata),
    .bridge_memory_address(bridge_memory_address),
    .bridge_memory_byte_enable(bridge_memory_byte_enable),
    .bridge_memory_read(bridge_memory_read), .bridge_memory_write(bridge_memory_write),
    .bridge_memory_write_data(bridge_memory_write_data),
    .bridge_memory_acknowledge(bridge_memory_acknowledge),
    .bridge_memory_read_data(bridge_memory_read_data),
    .err_timeout(err_timeout), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] bridge_rd(input logic [ADDR_W-1:0] a);
    if (a == 27'h100) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int rr_pick(input logic [N_CH-1:0] m, input int p);
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (p + k) % N_CH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    e.ch    = c;
    e.wr    = req_write[c];
    e.addr  = ch_addr[c];
    e.be    = ch_be[c];
    e.wdata = ch_wd[c];
    e.rdata = req_write[c] ? '0 : bridge_rd(ch_addr[c]);
    sb.push_back(e);
  endtask

  // Reference round-robin over the currently raised requests and drv_rep repeats
  task automatic plan();
    logic [N_CH-1:0] m;
    int r [N_CH];
    int g;
    m = req_read | req_write;
    for (int i = 0; i < N_CH; i++) r[i] = drv_rep[i];
    while (m != '0) begin
      g = rr_pick(m, model_ptr);
      push_exp(g);
      model_ptr = (g + 1) % N_CH;
      if (r[g] > 0) r[g]--;
      else m[g] = 1'b0;
    end
  endtask

  // Bridge responder: ack after resp_delay strobe cycles, read data always driven
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst || resp_ack) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if ((bridge_memory_read || bridge_memory_write) && resp_en) begin
        resp_cnt++;
        if (resp_cnt >= resp_delay) begin
          resp_ack = 1'b1;
          bridge_memory_read_data = bridge_rd(bridge_memory_address);
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Bridge-side monitor: strobes must match the scoreboard head while high
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bridge_memory_read || bridge_memory_write)) begin
        checks++;
        strobe_run++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe rd=%0b wr=%0b addr=%h", bridge_memory_read, bridge_memory_write, bridge_memory_address);
        end else if (bridge_memory_address !== sb[0].addr || bridge_memory_byte_enable !== sb[0].be ||
                     bridge_memory_write_data !== sb[0].wdata || bridge_memory_write !== sb[0].wr ||
                     bridge_memory_read !== !sb[0].wr) begin
          errors++;
          $display("FAIL bridge_outputs got addr=%h be=%b wd=%h rd=%b wr=%b want addr=%h be=%b wd=%h wr=%b",
                   bridge_memory_address, bridge_memory_byte_enable, bridge_memory_write_data,
                   bridge_memory_read, bridge_memory_write, sb[0].addr, sb[0].be, sb[0].wdata, sb[0].wr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  task automatic collect_acks(input int n, input int exp_strobe);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 100 * n + 50) begin
      @(negedge clk);
      cyc++;
      if (req_ack !== '0) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got=%b", req_ack);
        end else begin
          e = sb.pop_front();
          if (req_ack !== (4'b0001 << e.ch)) begin
            errors++;
            $display("FAIL ack_channel got=%b want=%b", req_ack, 4'b0001 << e.ch);
          end
          checks++;
          if (req_rdata !== e.rdata) begin
            errors++;
            $display("FAIL ack_rdata ch=%0d got=%h want=%h", e.ch, req_rdata, e.rdata);
          end
          checks++;
          if (strobe_run !== exp_strobe) begin
            errors++;
            $display("FAIL strobe_cycles ch=%0d got=%0d want=%0d", e.ch, strobe_run, exp_strobe);
          end
          if (drv_rep[e.ch] > 0) drv_rep[e.ch]--;
          else begin
            req_read[e.ch]  = 1'b0;
            req_write[e.ch] = 1'b0;
          end
        end
        strobe_run = 0;
        got++;
      end
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL ack_wait got=%0d want=%0d acks", got, n);
    end
  endtask

  task automatic set_ch(input int c, input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                        input logic [DATA_W-1:0] wd, input logic rd, input logic wr);
    ch_addr[c] = a;
    ch_be[c]   = be;
    ch_wd[c]   = wd;
    drv_rep[c] = 0;
    req_read[c]  = rd;
    req_write[c] = wr;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_CH; i++) begin
      ch_addr[i] = '0; ch_be[i] = '0; ch_wd[i] = '0; drv_rep[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ack !== '0 || req_rdata !== '0 || bridge_memory_read !== 1'b0 || bridge_memory_write !== 1'b0 ||
        bridge_memory_address !== '0 || bridge_memory_byte_enable !== '0 || bridge_memory_write_data !== '0 ||
        err_timeout !== 1'b0 || err_ch !== '0) begin
      errors++;
      $display("FAIL reset_state ack=%b rdata=%h rd=%b wr=%b addr=%h be=%b wd=%h err=%b ch=%0d",
               req_ack, req_rdata, bridge_memory_read, bridge_memory_write, bridge_memory_address,
               bridge_memory_byte_enable, bridge_memory_write_data, err_timeout, err_ch);
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_read();
    resp_delay = 3;
    @(negedge clk);
    set_ch(0, 27'h100, 2'b11, 16'h0000, 1'b1, 1'b0);
    plan();
    @(posedge clk);
    #1;
    checks++;
    if (bridge_memory_read !== 1'b1) begin
      errors++;
      $display("FAIL read_latency got=%b want=1", bridge_memory_read);
    end
    collect_acks(1, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ack !== '0 || req_rdata !== 16'hBEEF) begin
        errors++;
        $display("FAIL rdata_hold ack=%b rdata=%h want ack=0 rdata=beef", req_ack, req_rdata);
      end
    end
  endtask

  task automatic test_write();
    resp_delay = 2;
    @(negedge clk);
    set_ch(2, 27'h2A, 2'b10, 16'h1234, 1'b0, 1'b1);
    plan();
    collect_acks(1, 2);
  endtask

  task automatic test_wrap_skip();
    resp_delay = 1;
    @(negedge clk);
    set_ch(1, 27'h11, 2'b11, 16'h1111, 1'b1, 1'b0);
    set_ch(3, 27'h33, 2'b01, 16'h3333, 1'b1, 1'b0);
    plan();
    collect_acks(2, 1);
  endtask

  task automatic test_reset_mid_issue();
    int cyc = 0;
    resp_en = 1'b0;
    @(negedge clk);
    set_ch(1, 27'h77, 2'b01, 16'hCAFE, 1'b0, 1'b1);
    plan();
    while (bridge_memory_write !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bridge_memory_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue_write got=%b want=1", bridge_memory_write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bridge_memory_write !== 1'b0 || bridge_memory_read !== 1'b0 || req_ack !== '0) begin
      errors++;
      $display("FAIL reset_drop rd=%b wr=%b ack=%b want 0 0 0", bridge_memory_read, bridge_memory_write, req_ack);
    end
    req_write[1] = 1'b0;
    sb.delete();
    strobe_run = 0;
    model_ptr  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ack !== '0) begin
        errors++;
        $display("FAIL ack_after_reset got=%b want=0", req_ack);
      end
    end
    resp_delay = 2;
    set_ch(0, 27'h200, 2'b11, 16'h0A0A, 1'b1, 1'b0);
    set_ch(3, 27'h300, 2'b11, 16'h0B0B, 1'b1, 1'b0);
    plan();
    collect_acks(2, 2);
  endtask

  task automatic test_fairness();
    resp_delay = 2;
    @(negedge clk);
    for (int i = 0; i < N_CH; i++) set_ch(i, 27'(27'h400 + i * 4), 2'b11, 16'(i), 1'b1, 1'b0);
    drv_rep[0] = 1;
    drv_rep[1] = 1;
    plan();
    collect_acks(6, 2);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] last;
    resp_delay = 1;
    @(negedge clk);
    set_ch(0, 27'h500, 2'b11, 16'h9999, 1'b1, 1'b1);
    set_ch(1, 27'h501, 2'b11, 16'h0000, 1'b1, 1'b0);
    plan();
    collect_acks(2, 1);
    last = bridge_rd(27'h501);
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ack !== '0 || req_rdata !== last) begin
        errors++;
        $display("FAIL stray_ack ack=%b rdata=%h want ack=0 rdata=%h", req_ack, req_rdata, last);
      end
    end
    set_ch(2, 27'h600, 2'b01, 16'h0000, 1'b1, 1'b0);
    plan();
    collect_acks(1, 1);
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    resp_en = 1'b0;
    @(negedge clk);
    set_ch(1, 27'h700, 2'b11, 16'h0000, 1'b1, 1'b0);
    plan();
    sb[sb.size()-1].rdata = 16'hFFFF;
    collect_acks(1, 8);
    checks++;
    if (err_timeout !== 1'b1 || err_ch !== 2'd1) begin
      errors++;
      $display("FAIL timeout_flags err=%b ch=%0d want err=1 ch=1", err_timeout, err_ch);
    end
    resp_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    checks++;
    if (err_timeout !== 1'b0 || err_ch !== '0) begin
      errors++;
      $display("FAIL no_timeout_flags err=%b ch=%0d want 0 0", err_timeout, err_ch);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_wrap_skip();
    test_reset_mid_issue();
    test_fairness();
    test_back_to_back();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
